// File: rtl/optical_rx_deframer.sv
// optical_rx_deframer: recovers start/8N/stop bytes from the optical line and
// buffers them in a small byte FIFO with a valid/ready output.
// Define OPTRX_GLITCH_FILTER_EN for 2-of-3 majority bit sampling.
module optical_rx_deframer #(
  parameter int CPB        = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int          PTR_W   = $clog2(FIFO_DEPTH);
  localparam int          CW      = $clog2(CPB);
  localparam int unsigned DEPTH_U = FIFO_DEPTH;
`ifdef OPTRX_GLITCH_FILTER_EN
  localparam logic [CW-1:0] START_LD = CW'(CPB / 2);
`else
  localparam logic [CW-1:0] START_LD = CW'(CPB / 2 - 1);
`endif
  localparam logic [CW-1:0] BIT_LD = CW'(CPB - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             sync1, ds, ds_d;
  logic [1:0]       fill;
  logic             samp;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             push_req, err_req;
  logic             tick;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, pop, push_ok;

  // ds_d is held at 1 until the synchronizer has flushed its reset zeros,
  // so a line that is already high at release is not taken as a rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      ds    <= 1'b0;
      ds_d  <= 1'b1;
      fill  <= '0;
    end else begin
      sync1 <= data_in;
      ds    <= sync1;
      fill  <= {fill[0], 1'b1};
      ds_d  <= fill[1] ? ds : 1'b1;
    end
  end

`ifdef OPTRX_GLITCH_FILTER_EN
  logic ds_dd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ds_dd <= 1'b1;
    end else begin
      ds_dd <= ds_d;
    end
  end

  assign samp = (ds & ds_d) | (ds & ds_dd) | (ds_d & ds_dd);
`else
  assign samp = ds;
`endif

  assign tick = (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      shift     <= shift_nxt;
      frame_err <= err_req;
      overflow  <= push_req && full && !pop;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    push_req  = 1'b0;
    err_req   = 1'b0;
    if (state != IDLE) begin
      cnt_nxt = cnt - 1'b1;
    end
    case (state)
      IDLE: begin
        if (ds && !ds_d) begin
          bit_nxt   = '0;
          cnt_nxt   = START_LD;
          state_nxt = START;
        end
      end
      START: begin
        if (tick) begin
          if (samp) begin
            cnt_nxt   = BIT_LD;
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_nxt[bit_idx] = samp;
          cnt_nxt            = BIT_LD;
          bit_nxt            = 3'(bit_idx + 3'd1);
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (samp) begin
            err_req = 1'b1;
          end else begin
            push_req = 1'b1;
          end
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign full     = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign rx_valid = (count != '0);
  assign rx_data  = mem[rd_ptr];
  assign pop      = rx_valid && rx_ready;
  assign push_ok  = push_req && (!full || pop);
  assign busy     = (state != IDLE);

  // When full, a same-edge pop frees the head slot, which is also the write slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH_U; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_optical_rx_deframer.sv
module tb_optical_rx_deframer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef OPTRX_GLITCH_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif
  // Edge index (counted from the edge before the start bit is driven) at
  // which the stop-bit decision is registered.
  localparam int STOP_EDGE  = 3 + CPB / 2 + 9 * CPB + FILT;
  localparam int FRAME_CYCS = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overflow;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];

  optical_rx_deframer #(.CPB(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overflow) ov_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    data_in = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b1);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic compare_q(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int fe0, ov0, nbad, gap, k;
    logic [7:0] b;
    logic st;

    rst = 1'b0;
    data_in = 1'b0;
    rx_ready = 1'b0;
    tick(3);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    tick(5);

    // single good frame, consumer always ready
    rx_ready = 1'b1;
    got_q.delete();
    exp_q = '{8'hA5};
    send_frame(8'hA5, 1'b0);
    chk("a5_busy_mid", 32'(busy), 32'h1);
    tick(STOP_EDGE - FRAME_CYCS);
    chk("a5_valid", 32'(rx_valid), 32'h1);
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_busy_end", 32'(busy), 32'h0);
    tick(1);
    chk("a5_valid_drop", 32'(rx_valid), 32'h0);
    tick(4);
    chk("a5_fe", 32'(fe_cnt), 32'd0);
    chk("a5_ov", 32'(ov_cnt), 32'd0);
    compare_q("a5");

    // one-cycle line glitch
    got_q.delete();
    exp_q.delete();
    data_in = 1'b1;
    tick(1);
    data_in = 1'b0;
    tick(2);
    chk("glitch_busy_start", 32'(busy), 32'h1);
    tick(10);
    chk("glitch_busy_end", 32'(busy), 32'h0);
    chk("glitch_valid", 32'(rx_valid), 32'h0);
    chk("glitch_fe", 32'(fe_cnt), 32'd0);
    chk("glitch_ov", 32'(ov_cnt), 32'd0);
    compare_q("glitch");

    // stop bit high
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b1);
    data_in = 1'b0;
    tick(STOP_EDGE - FRAME_CYCS);
    chk("ferr_pulse", 32'(frame_err), 32'h1);
    tick(1);
    chk("ferr_pulse_end", 32'(frame_err), 32'h0);
    tick(4);
    chk("ferr_count", 32'(fe_cnt - fe0), 32'd1);
    chk("ferr_valid", 32'(rx_valid), 32'h0);
    compare_q("ferr");

    // overflow on the fifth byte
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b0);
      tick(6);
      chk($sformatf("ovf_none_%0d", i), 32'(ov_cnt - ov0), 32'd0);
    end
    send_frame(8'h05, 1'b0);
    tick(STOP_EDGE - FRAME_CYCS);
    chk("ovf_pulse", 32'(overflow), 32'h1);
    tick(1);
    chk("ovf_pulse_end", 32'(overflow), 32'h0);
    tick(4);
    chk("ovf_count", 32'(ov_cnt - ov0), 32'd1);
    chk("ovf_valid", 32'(rx_valid), 32'h1);
    chk("ovf_head_stable", 32'(rx_data), 32'h01);
    got_q.delete();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    rx_ready = 1'b1;
    tick(8);
    rx_ready = 1'b0;
    compare_q("ovf_drain");

    // full FIFO: push coincides with a pop
    for (int i = 0; i < 4; i++) begin
      send_frame(8'(8'h11 + i), 1'b0);
      tick(6);
    end
    got_q.delete();
    ov0 = ov_cnt;
    fork
      send_frame(8'h15, 1'b0);
      begin
        tick(STOP_EDGE - 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    tick(6);
    chk("fullpop_ov", 32'(ov_cnt - ov0), 32'd0);
    exp_q = '{8'h11};
    compare_q("fullpop_one");
    got_q.delete();
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h15};
    rx_ready = 1'b1;
    tick(8);
    rx_ready = 1'b0;
    compare_q("fullpop_drain");

    // reset in the middle of a frame
    send_frame(8'h77, 1'b0);
    tick(6);
    chk("rstmid_pre_valid", 32'(rx_valid), 32'h1);
    data_in = 1'b1;
    tick(4 * CPB);
    chk("rstmid_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("rstmid_valid", 32'(rx_valid), 32'h0);
    chk("rstmid_busy_clr", 32'(busy), 32'h0);
    chk("rstmid_data", 32'(rx_data), 32'h0);
    tick(3);
    rst = 1'b1;
    tick(12);
    chk("rstmid_high_idle", 32'(busy), 32'h0);
    data_in = 1'b0;
    tick(6);
    rx_ready = 1'b1;
    got_q.delete();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h5A, 1'b0);
    data_in = 1'b0;
    tick(8);
    exp_q = '{8'h5A};
    compare_q("rstmid");
    chk("rstmid_fe", 32'(fe_cnt - fe0), 32'd0);

    // random frames, consumer always ready, short or zero gaps
    got_q.delete();
    exp_q.delete();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    nbad = 0;
    for (int n = 0; n < 30; n++) begin
      b = 8'($urandom);
      st = ($urandom_range(0, 4) == 0);
      send_frame(b, st);
      if (st) nbad++;
      else exp_q.push_back(b);
      gap = st ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
      if (gap > 0) begin
        data_in = 1'b0;
        tick(gap);
      end
    end
    data_in = 1'b0;
    tick(10);
    compare_q("rand");
    chk("rand_fe", 32'(fe_cnt - fe0), 32'(nbad));
    chk("rand_ov", 32'(ov_cnt - ov0), 32'd0);

    // random bursts into a stalled consumer
    for (int r = 0; r < 4; r++) begin
      k = int'($urandom_range(1, 6));
      got_q.delete();
      exp_q.delete();
      ov0 = ov_cnt;
      rx_ready = 1'b0;
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom);
        send_frame(b, 1'b0);
        if (j < DEPTH) exp_q.push_back(b);
        gap = int'($urandom_range(0, 2));
        if (gap > 0) tick(gap);
      end
      tick(6);
      chk($sformatf("burst%0d_ov", r), 32'(ov_cnt - ov0), 32'((k > DEPTH) ? k - DEPTH : 0));
      chk($sformatf("burst%0d_valid", r), 32'(rx_valid), 32'h1);
      rx_ready = 1'b1;
      tick(10);
      rx_ready = 1'b0;
      compare_q($sformatf("burst%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
